// File: rtl/mem_bus_pkg.sv
// Shared CPU data-bus definitions: widths, store-trace record and byte-lane merge.
package mem_bus_pkg;

    localparam int WORD_W   = 32;
    localparam int BYTEEN_W = 4;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] word;
    } store_trace_t;

    // Replace each enabled byte lane of old_word with the matching lane of wdata.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0]   old_word,
        input logic [WORD_W-1:0]   wdata,
        input logic [BYTEEN_W-1:0] byteen
    );
        logic [WORD_W-1:0] result;
        result = old_word;
        for (int k = 0; k < BYTEEN_W; k++) begin
            if (byteen[k]) begin
                result[8*k +: 8] = wdata[8*k +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A write while full is accepted only
// when a read happens in the same cycle; the caller decides what a dropped write means.
module sync_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_fire;
    logic             wr_fire;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);
    assign rd_data = store_q[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (wr_fire) store_q[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dm_store_responder.sv
// Data-memory responder: combinational word reads, byte-enabled stores on clk,
// and a trace FIFO logging every committed store as {pc, word address, merged word}.
module dm_store_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int TRACE_DEPTH = 8,
    localparam int IDX_W      = $clog2(DEPTH),
    localparam int TCW        = $clog2(TRACE_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD_W-1:0]   m_data_addr,
    input  logic [BYTEEN_W-1:0] m_data_byteen,
    input  logic [WORD_W-1:0]   m_data_wdata,
    input  logic [WORD_W-1:0]   m_inst_addr,
    output logic [WORD_W-1:0]   m_data_rdata,
    output logic                trace_valid,
    input  logic                trace_ready,
    output logic [WORD_W-1:0]   trace_pc,
    output logic [WORD_W-1:0]   trace_addr,
    output logic [WORD_W-1:0]   trace_word,
    output logic [TCW-1:0]      trace_count,
    output logic                trace_ovf,
    output logic                oor_err
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    logic [29:0]       idx;
    logic [IDX_W-1:0]  widx;
    logic              in_range;
    logic [WORD_W-1:0] old_word;
    logic [WORD_W-1:0] merged;
    logic              store_commit;
    logic              pop;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    store_trace_t      push_entry;
    store_trace_t      head_entry;

    // Byte offset never selects a word; the trace records the aligned address.
    logic              unused_addr_lsb;
    assign unused_addr_lsb = ^m_data_addr[1:0];

    assign idx      = m_data_addr[31:2];
    assign widx     = idx[IDX_W-1:0];
    assign in_range = (idx < 30'(DEPTH));

    // Words never written since reset read as zero, so reset need not sweep the array.
    assign old_word     = (in_range && valid_q[widx]) ? mem_q[widx] : '0;
    assign m_data_rdata = old_word;

    assign merged       = merge_bytes(old_word, m_data_wdata, m_data_byteen);
    assign store_commit = !reset && (|m_data_byteen) && in_range;

    assign pop  = trace_valid && trace_ready;
    assign push = store_commit && (!fifo_full || pop);

    assign push_entry.pc   = m_inst_addr;
    assign push_entry.addr = {m_data_addr[31:2], 2'b00};
    assign push_entry.word = merged;

    // Per-word written bitmap, cleared in a single reset cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (store_commit) begin
            valid_q[widx] <= 1'b1;
        end
    end

    // Storage array, written with the merged word on every committed store.
    always_ff @(posedge clk) begin
        if (store_commit) mem_q[widx] <= merged;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_ovf <= 1'b0;
            oor_err   <= 1'b0;
        end else begin
            if (!in_range) oor_err <= 1'b1;
            if (store_commit && fifo_full && !pop) trace_ovf <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(store_trace_t)),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (push_entry),
        .rd_en   (trace_ready),
        .rd_data (head_entry),
        .count   (trace_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign trace_valid = !fifo_empty;
    assign trace_pc    = head_entry.pc;
    assign trace_addr  = head_entry.addr;
    assign trace_word  = head_entry.word;

endmodule
